// File: rtl/adder_pkg.sv
// Shared constants and types for the chunked pipelined adder.
// Default geometry: 16-bit operands, 4 bits per stage, so 4 stages.
package adder_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int ADDER_CHUNK = 4;

  function automatic int adder_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  localparam int ADDER_STAGES = adder_stages(ADDER_WIDTH, ADDER_CHUNK);

  // Per-stage control travelling alongside the data slot.
  typedef struct packed {
    logic vld;
    logic sub;
    logic c;
    logic cm;
  } stage_ctl_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder; also exports the carry into its MSB.
// Zero latency; no flow control of its own.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[CHUNK];
  assign cm = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined chunked adder with valid/ready handshake; ADDER_SUB_EN adds a subtract port.
// Latency WIDTH/CHUNK cycles; a single advance enable freezes every stage while the output is blocked.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = adder_stages(WIDTH, CHUNK);

  logic adv;
  logic in_sub;

  // x_q holds finished sum chunks at and below the stage, untouched A bits above.
  logic [WIDTH-1:0] x_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  stage_ctl_t       ctl_q [STAGES];

  logic [CHUNK-1:0] ch_a  [STAGES];
  logic [CHUNK-1:0] ch_b  [STAGES];
  logic [CHUNK-1:0] ch_s  [STAGES];
  logic             ch_ci [STAGES];
  logic             ch_co [STAGES];
  logic             ch_cm [STAGES];

`ifdef ADDER_SUB_EN
  assign in_sub = sub;
`else
  assign in_sub = 1'b0;
`endif

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] x,
                                                 input logic [CHUNK-1:0] s,
                                                 input int               k);
    logic [WIDTH-1:0] r;
    r = x;
    r[k*CHUNK +: CHUNK] = s;
    return r;
  endfunction

  // Subtraction is a + ~b + 1: invert B chunk-wise and force the first carry.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    if (k == 0) begin : g_first
      assign ch_a[k]  = a[0 +: CHUNK];
      assign ch_b[k]  = b[0 +: CHUNK] ^ {CHUNK{in_sub}};
      assign ch_ci[k] = in_sub | cin;
    end else begin : g_next
      assign ch_a[k]  = x_q[k-1][k*CHUNK +: CHUNK];
      assign ch_b[k]  = b_q[k-1][k*CHUNK +: CHUNK] ^ {CHUNK{ctl_q[k-1].sub}};
      assign ch_ci[k] = ctl_q[k-1].c;
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a  (ch_a[k]),
      .b  (ch_b[k]),
      .ci (ch_ci[k]),
      .s  (ch_s[k]),
      .co (ch_co[k]),
      .cm (ch_cm[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]   <= '0;
        b_q[k]   <= '0;
        ctl_q[k] <= '0;
      end
    end else if (adv) begin
      x_q[0]   <= put_chunk(a, ch_s[0], 0);
      b_q[0]   <= b;
      ctl_q[0] <= '{vld: in_valid, sub: in_sub, c: ch_co[0], cm: ch_cm[0]};
      for (int k = 1; k < STAGES; k++) begin
        x_q[k]   <= put_chunk(x_q[k-1], ch_s[k], k);
        b_q[k]   <= b_q[k-1];
        ctl_q[k] <= '{vld: ctl_q[k-1].vld, sub: ctl_q[k-1].sub, c: ch_co[k], cm: ch_cm[k]};
      end
    end
  end

  assign out_valid = ctl_q[STAGES-1].vld;
  assign sum       = x_q[STAGES-1];
  assign cout      = ctl_q[STAGES-1].c;
  assign ovf       = ctl_q[STAGES-1].cm ^ ctl_q[STAGES-1].c;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, CHUNK=4): vector table plus stall/bubble/reset sequences.
module tb_pipelined_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int   checks;
  int   errors;
  int   n_out;
  logic got_in;
  logic got_out;
  logic rdy_seen;
  vec_t tbl[$];
  vec_t sub_tbl[$];
  vec_t exp_q[$];
  vec_t idle;

  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                               input logic vs, input logic [15:0] es, input logic eco,
                               input logic eov);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.s = es; v.co = eco; v.ov = eov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, observe handshakes 1ns later, score any transfer.
  task automatic step(input logic iv, input vec_t v, input logic ordy, input logic r);
    vec_t e;
    @(negedge clk);
    rst = r; in_valid = iv; a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    out_ready = ordy;
    #1;
    got_out  = 1'b0;
    got_in   = 1'b0;
    rdy_seen = in_ready;
    if (!r && out_valid === 1'b1 && out_ready) begin
      got_out = 1'b1;
      n_out++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result sum=%h cout=%b ovf=%b", sum, cout, ovf);
      end else begin
        e = exp_q.pop_front();
        if (sum !== e.s || cout !== e.co || ovf !== e.ov) begin
          errors++;
          $display("FAIL result a=%h b=%h sub=%b: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   e.a, e.b, e.sub, sum, cout, ovf, e.s, e.co, e.ov);
        end
      end
    end
    if (!r && in_valid && in_ready === 1'b1) begin
      got_in = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, idle, 1'b1, 1'b0);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    int n0;
    int idx;
    checks = 0; errors = 0; n_out = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    idle = mkv(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    //              a          b          cin   sub   sum        cout  ovf
    tbl.push_back(mkv(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0));
    tbl.push_back(mkv(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
    tbl.push_back(mkv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
    tbl.push_back(mkv(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0));
    tbl.push_back(mkv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
    tbl.push_back(mkv(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
    tbl.push_back(mkv(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0));
    tbl.push_back(mkv(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0));
    tbl.push_back(mkv(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0));
    tbl.push_back(mkv(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));

    sub_tbl.push_back(mkv(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
    sub_tbl.push_back(mkv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
    sub_tbl.push_back(mkv(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0));

    // Operands offered while reset is held must never surface.
    step(1'b1, tbl[0], 1'b1, 1'b1);
    step(1'b1, tbl[1], 1'b1, 1'b1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    step(1'b0, idle, 1'b1, 1'b0);
    chk("reset_in_ready", rdy_seen, 1);
    for (int i = 0; i < 6; i++) step(1'b0, idle, 1'b1, 1'b0);
    chk("reset_no_stale", n_out, 0);

    // Single operand: result must appear exactly 4 cycles after acceptance.
    step(1'b1, tbl[0], 1'b1, 1'b0);
    chk("latency_accept", got_in, 1);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, idle, 1'b1, 1'b0);
      lat++;
      if (got_out) break;
    end
    chk("latency", lat, 4);

    // Full table back-to-back at one per cycle.
    n0 = n_out;
    foreach (tbl[i]) step(1'b1, tbl[i], 1'b1, 1'b0);
    drain("stream_drain");
    chk("stream_count", n_out - n0, tbl.size());

    // Eight back-to-back with the sink stalled in cycles 5-7.
    n0 = n_out; idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx >= 8 && exp_q.size() == 0) break;
      step(idx < 8, tbl[(idx < 8) ? idx : 0], !(c >= 5 && c <= 7), 1'b0);
      if (c >= 5 && c <= 7) chk("stall_in_ready", rdy_seen, 0);
      if (got_in) idx++;
    end
    chk("stall_count", n_out - n0, 8);
    chk("stall_empty", exp_q.size(), 0);

    // Bubbles mixed with an irregular out_ready pattern.
    for (int i = 0; i < 24; i++) step((i % 3) != 1, tbl[i % 10], (i % 4) != 3, 1'b0);
    drain("bubble_drain");

`ifdef ADDER_SUB_EN
    n0 = n_out;
    foreach (sub_tbl[i]) step(1'b1, sub_tbl[i], 1'b1, 1'b0);
    drain("sub_drain");
    chk("sub_count", n_out - n0, sub_tbl.size());
`endif

    // Reset with three operands in flight: all discarded, pipeline usable afterwards.
    step(1'b1, tbl[3], 1'b1, 1'b0);
    step(1'b1, tbl[4], 1'b1, 1'b0);
    step(1'b1, tbl[5], 1'b1, 1'b0);
    step(1'b1, tbl[6], 1'b1, 1'b1);
    exp_q.delete();
    chk("midrst_out_valid", out_valid, 0);
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, idle, 1'b1, 1'b0);
      if (i == 0) chk("midrst_in_ready", rdy_seen, 1);
    end
    chk("midrst_no_stale", n_out - n0, 0);
    step(1'b1, tbl[3], 1'b1, 1'b0);
    drain("midrst_drain");
    chk("midrst_count", n_out - n0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
